ehgu_segment_addr_encoder: RTL



---
 rtl/ehgu_seg_pkg.sv | 12 +
 rtl/ehgu_rr_arbiter.sv | 27 ++
 rtl/ehgu_segment_addr_encoder.sv | 60 ++++++
 3 files changed

// File: rtl/ehgu_seg_pkg.sv
// ehgu_seg_pkg: shared helpers for segment slot addressing
package ehgu_seg_pkg;
  function automatic int num_slots(input int sw);
    return 1 << sw;
  endfunction
  function automatic logic [63:0] seg_addr(input logic [63:0] lcl, input logic [63:0] idx, input int sw);
    return (lcl << sw) | idx;
  endfunction
  function automatic int rr_next(input int p, input int n);
    return (p + 1) % n;
  endfunction
endpackage

// File: rtl/ehgu_rr_arbiter.sv
// ehgu_rr_arbiter: combinational round-robin pick starting at ptr
module ehgu_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  // first requester at or above ptr, wrapping back to slot 0
  always_comb begin
    logic found;
    int j;
    onehot = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        onehot[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ehgu_segment_addr_encoder.sv
// ehgu_segment_addr_encoder: arbitrates slot requests into {LOCAL_ADDR, idx} addresses
module ehgu_segment_addr_encoder
  import ehgu_seg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG_WIDTH = 2,
  parameter int LOCAL_ADDR = 0,
  parameter int CNT_WIDTH = 16,
  localparam int N = num_slots(SEG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [WIDTH-1:0]     out_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] txn_cnt
);
  logic [N-1:0]         win_oh;
  logic [SEG_WIDTH-1:0] win_idx;
  logic [SEG_WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]     out_addr_q, out_addr_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] txn_cnt_q, txn_cnt_d;
  logic                 load_en, accept;
  ehgu_rr_arbiter #(.N(N)) u_arb (
    .req(req),
    .ptr(ptr_q),
    .onehot(win_oh),
    .idx(win_idx)
  );
  // a new address loads whenever the output register is free or draining this cycle
  always_comb begin
    accept = out_valid_q && out_ready;
    load_en = |req && (!out_valid_q || out_ready);
    gnt = (load_en && !rst) ? win_oh : '0;
    out_valid_d = load_en ? 1'b1 : (accept ? 1'b0 : out_valid_q);
    out_addr_d = load_en ? WIDTH'(seg_addr(64'(LOCAL_ADDR), 64'(win_idx), SEG_WIDTH)) : out_addr_q;
    ptr_d = load_en ? SEG_WIDTH'(rr_next(int'(win_idx), N)) : ptr_q;
    txn_cnt_d = txn_cnt_q + CNT_WIDTH'(accept);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      out_addr_q <= '0;
      out_valid_q <= 1'b0;
      txn_cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      out_addr_q <= out_addr_d;
      out_valid_q <= out_valid_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end
  assign out_addr = out_addr_q;
  assign out_valid = out_valid_q;
  assign txn_cnt = txn_cnt_q;
endmodule
